subleq_sequencer: RTL and testbench
===================================

// Module: subleq_sequencer
// PURPOSE
//   Control sequencer for the SUBLEQ CPU. Drives the 64-bit word memory's
//   address, read-enable and write-enable ports and consumes its
//   registered read data. Executes
//   mem[B] <= mem[B] - mem[A]; if result <= 0 then PC <= C else PC <= PC+3.
//   Operands A, B, C are the words at PC, PC+1, PC+2.
//   Sits directly upstream of the memory; the memory is the only datapath.
// PARAMETERS
//   DATA_W    64     word / address width (memory word is the address unit)
//   RESET_PC  0      PC value loaded on reset
//   CNT_W     32     width of retired-instruction counter
// PORTS
//   clk          in   1       clock, all state updates on rising edge
//   rst          in   1       reset, synchronous, active-high
//   start        in   1       one-cycle pulse; leaves IDLE, begins execution at pc
//   mem_addr     out  DATA_W  memory address
//   mem_wdata    out  DATA_W  memory write data
//   mem_we       out  1       memory write enable
//   mem_re       out  1       memory read enable
//   mem_rdata    in   DATA_W  memory read data; valid the cycle after mem_re
//   pc           out  DATA_W  current program counter
//   busy         out  1       high in any state except IDLE and HALT
//   halted       out  1       sticky; high in HALT
//   retire       out  1       one-cycle pulse in the EXEC cycle
//   instr_count  out  CNT_W   retired-instruction count, wraps mod 2^CNT_W
// BEHAVIOUR
//   Reset: state=IDLE, pc=RESET_PC, a/b/c/op_a regs=0, instr_count=0.
//     All outputs are 0 except pc.
//   Memory contract: 1-cycle read latency. Data for the mem_re issued in
//     cycle k is sampled from mem_rdata at the end of cycle k+1.
//     mem_re and mem_we are never both high.
//   States and per-cycle actions (6 cycles per instruction):
//     IDLE    : all strobes low; start=1 -> FETCH_A.
//     FETCH_A : re, addr=pc                                   -> FETCH_B
//     FETCH_B : re, addr=pc+1; a_ptr<=rdata                   -> FETCH_C
//     FETCH_C : re, addr=pc+2; b_ptr<=rdata                   -> LOAD_A
//     LOAD_A  : re, addr=a_ptr; c_ptr<=rdata                  -> LOAD_B
//     LOAD_B  : re, addr=b_ptr; op_a<=rdata                   -> EXEC
//     EXEC    : we, addr=b_ptr, wdata=res=rdata-op_a; retire=1;
//               instr_count++ ; branch taken iff $signed(res)<=0.
//               Taken and c_ptr[DATA_W-1]=1 -> pc unchanged, HALT.
//               Taken otherwise             -> pc<=c_ptr, FETCH_A.
//               Not taken                   -> pc<=pc+3, FETCH_A.
//     HALT    : all strobes low, halted=1; only rst exits.
//   Arithmetic: two's-complement subtraction, wraps mod 2^DATA_W, no
//     overflow detection. pc+1, pc+2, pc+3 wrap mod 2^DATA_W.
//     Full 64-bit addresses are driven; memory decodes the low bits.
//   A==B: res=0, so the branch is taken.
//   Self-modifying code: an EXEC write to pc..pc+2 is visible to the next
//     FETCH (write commits before the next read).
//   start while not IDLE: ignored. rst in any state: IDLE next cycle, any
//     in-flight write suppressed (mem_we low during rst).
//   mem_wdata=0 whenever mem_we=0.
// STRUCTURE
//   subleq_pkg: state enum (IDLE,FETCH_A,FETCH_B,FETCH_C,LOAD_A,LOAD_B,
//     EXEC,HALT), DATA_W constant, INSTR_WORDS=3.
//   Sub-module subleq_alu (combinational): in op_b, op_a; out res, le_zero.
//   Sequencer: one FSM plus pc / pointer / operand / counter registers.
// TESTING (bench uses a 1-cycle-latency memory model of 1024 words)
//   Reset -> pc=0, busy=0, halted=0, all strobes 0; start ignored while
//     rst=1.
//   mem[0..2]=3,4,6; mem[3]=5, mem[4]=7, mem[6..8]=0,0,-1; start
//     -> mem[4]=2, branch not taken, pc=3.
//   Same program with mem[4]=5 -> mem[4]=0, taken, pc=6.
//   At 6: mem[0]-mem[0]=0, taken, C=-1 -> halted=1, instr_count=2.
//   Exact strobe trace for one instruction: re on cycles 1-5, we on
//     cycle 6 only, retire on cycle 6, mem_addr sequence pc,pc+1,pc+2,A,B,B.
//   Overflow: op_b=0x8000_0000_0000_0000, op_a=1 -> res=0x7FFF..FF
//     (positive), not taken.
//   pc=0xFFFF_FFFF_FFFF_FFFE -> fetch addrs ..FE, ..FF, 0; not taken gives
//     pc=1.
//   rst asserted during LOAD_B -> next cycle IDLE, no write to mem[B].
//   Self-modify: an instruction that writes its own successor's A word
//     -> the next fetch returns the new value.

Source files
------------

// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ control sequencer.
// Provides the FSM state enum, word width and instruction length.
package subleq_pkg;

  localparam int DATA_W      = 64;
  localparam int INSTR_WORDS = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    FETCH_C,
    LOAD_A,
    LOAD_B,
    EXEC,
    HALT
  } state_t;

endpackage

// File: rtl/subleq_alu.sv
// Combinational SUBLEQ ALU: res = op_b - op_a (wrapping).
// Ports: op_b, op_a in; res, le_zero (signed res <= 0) out.
module subleq_alu #(
  parameter int W = 64
) (
  input  logic [W-1:0] op_b,
  input  logic [W-1:0] op_a,
  output logic [W-1:0] res,
  output logic         le_zero
);

  assign res     = op_b - op_a;
  assign le_zero = res[W-1] | (res == '0);

endmodule

// File: rtl/subleq_sequencer.sv
// SUBLEQ control sequencer: 6-cycle fetch/load/exec over a 1-cycle memory.
// Ports: clk, rst, start; mem_* bus; pc, busy, halted, retire, instr_count.
module subleq_sequencer #(
  parameter int                DATA_W   = subleq_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              retire,
  output logic [CNT_W-1:0]  instr_count
);

  import subleq_pkg::*;

  localparam logic [DATA_W-1:0] STEP = DATA_W'(INSTR_WORDS);

  state_t state;
  state_t state_n;

  logic [DATA_W-1:0] a_ptr;
  logic [DATA_W-1:0] b_ptr;
  logic [DATA_W-1:0] c_ptr;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] res;
  logic              le_zero;

  // Minuend is the B operand arriving on the read bus during EXEC.
  subleq_alu #(
    .W(DATA_W)
  ) u_alu (
    .op_b   (mem_rdata),
    .op_a   (op_a),
    .res    (res),
    .le_zero(le_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = FETCH_A;
      FETCH_A: state_n = FETCH_B;
      FETCH_B: state_n = FETCH_C;
      FETCH_C: state_n = LOAD_A;
      LOAD_A:  state_n = LOAD_B;
      LOAD_B:  state_n = EXEC;
      EXEC: begin
        // A negative branch target is the halt convention.
        if (le_zero && c_ptr[DATA_W-1]) state_n = HALT;
        else                            state_n = FETCH_A;
      end
      HALT:    state_n = HALT;
    endcase
  end

  // Strobes are gated by rst so an in-flight write never lands.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    retire    = 1'b0;
    if (!rst) begin
      unique case (state)
        FETCH_A: begin
          mem_re   = 1'b1;
          mem_addr = pc;
        end
        FETCH_B: begin
          mem_re   = 1'b1;
          mem_addr = pc + DATA_W'(1);
        end
        FETCH_C: begin
          mem_re   = 1'b1;
          mem_addr = pc + DATA_W'(2);
        end
        LOAD_A: begin
          mem_re   = 1'b1;
          mem_addr = a_ptr;
        end
        LOAD_B: begin
          mem_re   = 1'b1;
          mem_addr = b_ptr;
        end
        EXEC: begin
          mem_we    = 1'b1;
          mem_addr  = b_ptr;
          mem_wdata = res;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);

  // Read data lags the request by one cycle, so each state
  // captures the word requested by the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      a_ptr       <= '0;
      b_ptr       <= '0;
      c_ptr       <= '0;
      op_a        <= '0;
      instr_count <= '0;
    end else begin
      unique case (state)
        FETCH_B: a_ptr <= mem_rdata;
        FETCH_C: b_ptr <= mem_rdata;
        LOAD_A:  c_ptr <= mem_rdata;
        LOAD_B:  op_a  <= mem_rdata;
        EXEC: begin
          instr_count <= instr_count + CNT_W'(1);
          if (!le_zero)             pc <= pc + STEP;
          else if (!c_ptr[DATA_W-1]) pc <= c_ptr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Directed bench for subleq_sequencer with 1-cycle memory models.
// Expected writes go through a scoreboard queue checked at retire.
module tb_subleq_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s1, s2;
  logic [63:0] a1, wd1, rd1, pc1;
  logic [63:0] a2, wd2, rd2, pc2;
  logic        we1, re1, busy1, halt1, ret1;
  logic        we2, re2, busy2, halt2, ret2;
  logic [31:0] cnt1, cnt2;

  subleq_sequencer dut (
    .clk(clk), .rst(rst), .start(s1),
    .mem_addr(a1), .mem_wdata(wd1),
    .mem_we(we1), .mem_re(re1), .mem_rdata(rd1),
    .pc(pc1), .busy(busy1), .halted(halt1),
    .retire(ret1), .instr_count(cnt1)
  );

  subleq_sequencer #(
    .RESET_PC(64'hFFFF_FFFF_FFFF_FFFE)
  ) dut2 (
    .clk(clk), .rst(rst), .start(s2),
    .mem_addr(a2), .mem_wdata(wd2),
    .mem_we(we2), .mem_re(re2), .mem_rdata(rd2),
    .pc(pc2), .busy(busy2), .halted(halt2),
    .retire(ret2), .instr_count(cnt2)
  );

  logic [63:0] mem1 [1024];
  logic [63:0] mem2 [1024];
  logic        bd_we  = 1'b0;
  logic        bd_sel = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [63:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we && !bd_sel)  mem1[bd_addr] <= bd_data;
    else if (we1)          mem1[a1[9:0]] <= wd1;
    if (re1)               rd1 <= mem1[a1[9:0]];
    if (bd_we && bd_sel)   mem2[bd_addr] <= bd_data;
    else if (we2)          mem2[a2[9:0]] <= wd2;
    if (re2)               rd2 <= mem2[a2[9:0]];
  end

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic sel, input int adr,
                      input logic [63:0] d);
    bd_sel  = sel;
    bd_addr = 10'(adr);
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic sel);
    if (sel) s2 = 1'b1;
    else     s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    s2 = 1'b0;
  endtask

  task automatic wait_retire(input logic sel);
    int  n = 0;
    wr_t e;
    while (!(sel ? ret2 : ret1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("retire_seen", 64'(sel ? ret2 : ret1), 64'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("wr_addr", sel ? a2 : a1, e.addr);
      chk("wr_data", sel ? wd2 : wd1, e.data);
      chk("wr_we", 64'(sel ? we2 : we1), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] ta [6];
    s1 = 1'b0;
    s2 = 1'b0;
    ta = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd4};

    // Reset state; start is held high and must be ignored.
    rst = 1'b1;
    s1  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc1, 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_halt", 64'(halt1), 64'd0);
    chk("rst_re", 64'(re1), 64'd0);
    chk("rst_we", 64'(we1), 64'd0);
    chk("rst_ret", 64'(ret1), 64'd0);
    chk("rst_addr", a1, 64'd0);
    chk("rst_cnt", 64'(cnt1), 64'd0);
    chk("rst_pc2", pc2, 64'hFFFF_FFFF_FFFF_FFFE);
    s1  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 64'(busy1), 64'd0);

    // Program: mem[4] = 7 - 5 = 2, not taken.
    poke(0, 0, 64'd3);
    poke(0, 1, 64'd4);
    poke(0, 2, 64'd6);
    poke(0, 3, 64'd5);
    poke(0, 4, 64'd7);
    poke(0, 6, 64'd0);
    poke(0, 7, 64'd0);
    poke(0, 8, 64'hFFFF_FFFF_FFFF_FFFF);

    // Cycle-exact strobe trace of one instruction.
    sb.push_back('{addr: 64'd4, data: 64'd2});
    s1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s1 = 1'b0;
      chk($sformatf("tr_re%0d", i), 64'(re1), 64'(i < 5));
      chk($sformatf("tr_we%0d", i), 64'(we1), 64'(i == 5));
      chk($sformatf("tr_ret%0d", i), 64'(ret1), 64'(i == 5));
      chk($sformatf("tr_addr%0d", i), a1, ta[i]);
      if (i == 5) wait_retire(0);
    end
    @(negedge clk);
    chk("nt_pc", pc1, 64'd3);
    chk("nt_cnt", 64'(cnt1), 64'd1);
    chk("nt_mem4", mem1[4], 64'd2);

    // Same program, mem[4] = 5: taken to 6, then halt.
    do_reset();
    poke(0, 4, 64'd5);
    sb.push_back('{addr: 64'd4, data: 64'd0});
    sb.push_back('{addr: 64'd0, data: 64'd0});
    pulse(0);
    wait_retire(0);
    @(negedge clk);
    chk("tk_pc", pc1, 64'd6);
    wait_retire(0);
    @(negedge clk);
    chk("halt", 64'(halt1), 64'd1);
    chk("halt_busy", 64'(busy1), 64'd0);
    chk("halt_pc", pc1, 64'd6);
    chk("halt_cnt", 64'(cnt1), 64'd2);
    chk("halt_mem4", mem1[4], 64'd0);
    pulse(0);
    @(negedge clk);
    chk("halt_sticky", 64'(halt1), 64'd1);
    chk("halt_re", 64'(re1), 64'd0);

    // Signed overflow: 0x8000.. - 1 is positive, not taken.
    do_reset();
    poke(0, 0, 64'd3);
    poke(0, 1, 64'd4);
    poke(0, 2, 64'd9);
    poke(0, 3, 64'd1);
    poke(0, 4, 64'h8000_0000_0000_0000);
    sb.push_back('{addr: 64'd4, data: 64'h7FFF_FFFF_FFFF_FFFF});
    pulse(0);
    wait_retire(0);
    @(negedge clk);
    chk("ov_pc", pc1, 64'd3);

    // Self-modify: writes mem[3], successor's A word.
    do_reset();
    poke(0, 0, 64'd10);
    poke(0, 1, 64'd3);
    poke(0, 2, 64'd20);
    poke(0, 3, 64'd50);
    poke(0, 10, 64'd8);
    sb.push_back('{addr: 64'd3, data: 64'd42});
    pulse(0);
    wait_retire(0);
    repeat (4) @(negedge clk);
    chk("sm_re", 64'(re1), 64'd1);
    chk("sm_a_ptr", a1, 64'd42);

    // Reset during LOAD_B suppresses the write.
    do_reset();
    poke(0, 0, 64'd3);
    poke(0, 1, 64'd4);
    poke(0, 2, 64'd6);
    poke(0, 3, 64'd5);
    poke(0, 4, 64'd7);
    pulse(0);
    repeat (4) @(negedge clk);
    chk("lb_addr", a1, 64'd4);
    rst = 1'b1;
    #1;
    chk("lb_we_rst", 64'(we1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("lb_busy", 64'(busy1), 64'd0);
    chk("lb_we", 64'(we1), 64'd0);
    repeat (3) @(negedge clk);
    chk("lb_mem4", mem1[4], 64'd7);
    chk("lb_cnt", 64'(cnt1), 64'd0);

    // PC wrap from 0xFF..FE on the second instance.
    poke(1, 10'h3FE, 64'd3);
    poke(1, 10'h3FF, 64'd4);
    poke(1, 0, 64'd6);
    poke(1, 3, 64'd5);
    poke(1, 4, 64'd7);
    sb.push_back('{addr: 64'd4, data: 64'd2});
    pulse(1);
    chk("wr_a0", a2, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    chk("wr_a1", a2, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("wr_a2", a2, 64'd0);
    wait_retire(1);
    @(negedge clk);
    chk("wr_pc", pc2, 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
